// File: rtl/product_accumulator.sv
// Block accumulator: sums COUNT unsigned products per result, valid/ready on both sides.
// Optional macro PRODUCT_ACC_SAT_EN selects saturating (clamp to all-ones) overflow instead of wrap.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4,
    parameter int CNT_W  = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_sum;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_last;
    logic [ACC_W:0]     w_base;
    logic [ACC_W:0]     w_add;
    logic               w_ovf_blk;
    logic [ACC_W-1:0]   w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_last       = (COUNT == 1);
                    w_state_next = (COUNT == 1) ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (r_cnt == LAST_CNT)) begin
                    w_last       = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // A new block starts from zero, so the running sum only feeds the adder in ACC.
    assign w_base    = (r_state == S_ACC) ? {1'b0, r_acc} : '0;
    assign w_add     = w_base + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign w_ovf_blk = ((r_state == S_ACC) & r_ovf) | w_add[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
    assign w_acc_next = w_ovf_blk ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
    assign w_acc_next = w_add[ACC_W-1:0];
`endif

    // Result registers load only on the final accept so they stay frozen outside that moment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_ovf <= w_ovf_blk;
            r_cnt <= (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum     <= w_acc_next;
                r_out_ovf <= w_ovf_blk;
            end
        end
    end

    assign out_sum = r_sum;
    assign out_ovf = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 16-bit and a 9-bit instance share stimulus,
// and a scoreboard of expected block results is checked on every emit.
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_product;
    logic        out_ready;
    logic        in_ready,  in_ready9;
    logic        out_valid, out_valid9;
    logic [15:0] out_sum;
    logic [8:0]  out_sum9;
    logic        out_ovf,   out_ovf9;
    logic        busy,      busy9;

    product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(4)) dut9 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9),
        .in_product(in_product), .out_valid(out_valid9), .out_ready(out_ready),
        .out_sum(out_sum9), .out_ovf(out_ovf9), .busy(busy9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s16;
        bit o16;
        int s9;
        bit o9;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_emit = 0;
    int   n_ov   = 0;
    int   n_nr   = 0;
    bit   acc_seen;
    int   m16, m9, mcnt;
    bit   mo16, mo9;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void upd(inout int m, inout bit o, input int p, input int w);
        int s;
        s = m + p;
        if (s >= (1 << w)) o = 1'b1;
`ifdef PRODUCT_ACC_SAT_EN
        if (o) s = (1 << w) - 1;
`else
        s = s % (1 << w);
`endif
        m = s;
    endfunction

    task automatic model_reset();
        m16 = 0; m9 = 0; mcnt = 0; mo16 = 1'b0; mo9 = 1'b0;
    endtask

    task automatic model_add(input int p);
        exp_t e;
        upd(m16, mo16, p, 16);
        upd(m9, mo9, p, 9);
        mcnt++;
        if (mcnt == 4) begin
            e.s16 = m16; e.o16 = mo16; e.s9 = m9; e.o9 = mo9;
            sb.push_back(e);
            model_reset();
        end
    endtask

    // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        acc_seen = in_valid && in_ready && !rst;
        if (out_valid) n_ov++;
        if (!in_ready) n_nr++;
        chk("valid9_match", {31'b0, out_valid9}, {31'b0, out_valid});
        chk("ready9_match", {31'b0, in_ready9}, {31'b0, in_ready});
        if (out_valid && out_ready && !rst) begin
            n_emit++;
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sum16", {16'b0, out_sum}, e.s16);
                chk("ovf16", {31'b0, out_ovf}, {31'b0, e.o16});
                chk("sum9",  {23'b0, out_sum9}, e.s9);
                chk("ovf9",  {31'b0, out_ovf9}, {31'b0, e.o9});
                $display("emit: sum16=%0d ovf16=%0b sum9=%0d ovf9=%0b", out_sum, out_ovf, out_sum9, out_ovf9);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present a product and hold in_valid until it is accepted; in_valid stays high afterwards.
    task automatic send(input int p);
        bit done;
        done       = 1'b0;
        in_valid   = 1'b1;
        in_product = p[7:0];
        for (int k = 0; k < 20 && !done; k++) begin
            cyc();
            if (acc_seen) done = 1'b1;
        end
        chk("accept_timeout", {31'b0, done}, 32'd1);
        if (done) begin
            model_add(p);
            $display("accept: product=%0d", p);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst = 1'b1; in_valid = 1'b0; in_product = 8'd0; out_ready = 1'b0;
        model_reset();
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_out_sum",   {16'b0, out_sum},   32'd0);
        chk("rst_out_ovf",   {31'b0, out_ovf},   32'd0);

        // 1: four 225s with in_valid held, then result held in HOLD
        for (int i = 0; i < 4; i++) send(225);
        in_valid = 1'b0;
        chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_in_ready",  {31'b0, in_ready},  32'd0);
        chk("t1_out_sum",   {16'b0, out_sum},   32'd900);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t1_valid_drop", {31'b0, out_valid}, 32'd0);
        chk("t1_ready_back", {31'b0, in_ready},  32'd1);
        chk("t1_sum_kept",   {16'b0, out_sum},   32'd900);

        // 2: backpressure for 5 cycles with a product offered during HOLD
        send(10); send(20); send(30); send(40);
        in_product = 8'd99;
        for (int i = 0; i < 5; i++) begin
            chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
            chk("t2_out_sum",   {16'b0, out_sum},   32'd100);
            chk("t2_in_ready",  {31'b0, in_ready},  32'd0);
            cyc();
            chk("t2_no_accept", {31'b0, acc_seen},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("t2_valid_drop", {31'b0, out_valid}, 32'd0);
        chk("t2_ready_back", {31'b0, in_ready},  32'd1);

        // 3: gaps of 3 idle cycles between products
        e0 = n_emit;
        for (int i = 1; i <= 4; i++) begin
            send(i);
            in_valid = 1'b0;
            if (i < 4) begin
                chk("t3_busy", {31'b0, busy}, 32'd1);
                for (int g = 0; g < 3; g++) begin
                    cyc();
                    chk("t3_busy_gap", {31'b0, busy}, 32'd1);
                end
            end
        end
        chk("t3_busy_hold", {31'b0, busy}, 32'd0);
        cyc(); cyc(); cyc();
        chk("t3_emit_once", n_emit - e0, 32'd1);

        // 4: reset mid-block discards the partial sum
        out_ready = 1'b0;
        send(50); send(60);
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        chk("t4_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_out_sum",   {16'b0, out_sum},   32'd0);
        chk("t4_out_sum9",  {23'b0, out_sum9},  32'd0);
        chk("t4_out_ovf",   {31'b0, out_ovf},   32'd0);
        chk("t4_busy",      {31'b0, busy},      32'd0);
        chk("t4_in_ready",  {31'b0, in_ready},  32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(1);
        in_valid = 1'b0;
        cyc();

        // 6: back-to-back blocks with out_ready high
        n_ov = 0; n_nr = 0; e0 = n_emit;
        for (int i = 0; i < 4; i++) send(5);
        for (int i = 0; i < 4; i++) send(7);
        in_valid = 1'b0;
        cyc(); cyc();
        chk("t6_emits",       n_emit - e0, 32'd2);
        chk("t6_valid_cycles", n_ov, 32'd2);
        chk("t6_notready_cycles", n_nr, 32'd2);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
